regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port integer register file with per-register busy/ROB-tag tracking.
//  Next generation of the single-issue regfile: NR read ports, NW commit ports, one rename port.
//  Sits between decode/rename (rename and read ports) and ROB commit (commit ports).
// PARAMETERS
//  XLEN   32  data width
//  NREG   32  architectural registers; x0 is hard-wired zero; REG_W=$clog2(NREG)
//  TAG_W  5   ROB tag width
//  NR     2   read ports
//  NW     2   commit ports; index NW-1 is the youngest commit
// PORTS
//  clk           in   1          clock
//  rst           in   1          synchronous, active-high reset
//  en            in   1          global advance (host ready); 0 = hold all state
//  flush         in   1          mispredict: clear every busy bit
//  cm_valid      in   NW         commit port valid
//  cm_id         in   NW*REG_W   destination register
//  cm_tag        in   NW*TAG_W   ROB tag of committing instruction
//  cm_val        in   NW*XLEN    committed value
//  rn_valid      in   1          rename: mark rn_rd busy with rn_tag
//  rn_rd         in   REG_W      renamed register
//  rn_tag        in   TAG_W      new producer tag
//  rd_id         in   NR*REG_W   read address per port
//  rd_busy       out  NR         operand not yet available
//  rd_tag        out  NR*TAG_W   producer tag when busy
//  rd_val        out  NR*XLEN    value (valid when rd_busy=0)
//  ckpt_save     in   1          snapshot busy/tag table (CONFIGURATION)
//  ckpt_restore  in   1          restore snapshot instead of flush-clear
//  ckpt_valid    out  1          a snapshot is held
// BEHAVIOUR
//  - rst: all values, tags, busy bits and ckpt_valid = 0; outputs for every rd_id read 0/0/0.
//  - Reads combinational, zero latency. x0: busy=0, tag=0, val=0 always; writes/renames to x0 dropped.
//  - en=0: no state change; reads show stored state, no bypass.
//  - Commit port k: value[id] <= val; busy cleared only if cm_tag == tag[id] (stale commit keeps busy).
//  - Same reg on several commit ports in one cycle: highest port index wins for value and tag-match test.
//  - Rename and commit to same reg in one cycle: value written, tag <= rn_tag, busy stays 1.
//  - Read bypass (en=1), priority high->low: rename hit -> busy=1, tag=rn_tag, val=stored/committed;
//    tag-matching commit hit -> busy=0, val=cm_val (youngest port); else stored state.
//  - flush (en=1): commits still write values; all busy <= 0; rename ignored; tags retained.
//  - flush and ckpt_restore together: ckpt_restore takes precedence when feature compiled in.
// CONFIGURATION
//  REGFILE_CHECKPOINT_EN defined:
//   - ckpt_save (en=1): snapshot <= busy/tag table after this cycle's commits, before this cycle's rename;
//     ckpt_valid <= 1. Save while valid overwrites.
//   - Snapshot tracks commits: a commit whose tag matches snapshot tag clears snapshot busy.
//   - ckpt_restore with ckpt_valid: live table <= snapshot (with this cycle's commits applied),
//     rename ignored, ckpt_valid <= 0. Restore without ckpt_valid behaves as flush.
//   - save and restore same cycle: restore wins, then ckpt_valid <= 0.
//  Not defined: ckpt_save/ckpt_restore ignored, ckpt_valid tied 0, no snapshot storage.
// STRUCTURE
//  regfile_pkg: XLEN, NREG, REG_W, TAG_W defaults, tag_t and reg_id_t typedefs.
//  Sub-module regfile_busy_table (NREG busy bits + tags, commit-clear logic): live instance
//  always; second instance as snapshot under REGFILE_CHECKPOINT_EN.
// TESTING
//  1 rst, read x5 -> busy=0 tag=0 val=0; rename x0 tag 3 then read x0 -> busy=0 val=0.
//  2 rename x5 tag 7; next cycle commit x5 tag 7 val 0xAB while reading x5 -> busy=0 val=0xAB;
//    next cycle read -> busy=0 val=0xAB.
//  3 rename x5 tag 7, rename x5 tag 9, commit x5 tag 7 val 1 -> x5 busy=1 tag=9, value=1.
//  4 same cycle: port0 commit x6 tag 2 val 10, port1 commit x6 tag 4 val 20, tag[x6]=4 ->
//    value 20, busy cleared.
//  5 x3,x4 busy; flush with commit x3 match val 5 -> all busy 0, x3=5; en=0 cycle changes nothing.
//  6 (CHECKPOINT_EN) x3 busy tag 1; save; rename x4 tag 2; commit x3 tag 1; restore ->
//    x3 busy=0, x4 busy=0, ckpt_valid=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and typedefs for the multi-port register file
package regfile_pkg;
    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int REG_W = $clog2(NREG);
    localparam int TAG_W = 5;
    typedef logic [REG_W-1:0] reg_id_t;
    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [XLEN-1:0]  word_t;
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: rename, read, commit and checkpoint bus of regfile_mp
interface regfile_mp_if import regfile_pkg::*; #(parameter int NR = 2, parameter int NW = 2);
    logic          en, flush, rn_valid, ckpt_save, ckpt_restore, ckpt_valid;
    logic [NW-1:0] cm_valid;
    reg_id_t       cm_id [NW];
    tag_t          cm_tag [NW];
    word_t         cm_val [NW];
    reg_id_t       rn_rd;
    tag_t          rn_tag;
    reg_id_t       rd_id [NR];
    logic [NR-1:0] rd_busy;
    tag_t          rd_tag [NR];
    word_t         rd_val [NR];
    modport master (output en, flush, cm_valid, cm_id, cm_tag, cm_val, rn_valid, rn_rd, rn_tag,
                    rd_id, ckpt_save, ckpt_restore, input rd_busy, rd_tag, rd_val, ckpt_valid);
    modport slave (input en, flush, cm_valid, cm_id, cm_tag, cm_val, rn_valid, rn_rd, rn_tag,
                   rd_id, ckpt_save, ckpt_restore, output rd_busy, rd_tag, rd_val, ckpt_valid);
endinterface

// File: rtl/regfile_busy_table.sv
// regfile_busy_table: per-register busy bit and producer tag with tag-matched commit clearing
module regfile_busy_table import regfile_pkg::*; #(parameter int NW = 2) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            clear,
    input  logic            load,
    input  logic            rn_valid,
    input  reg_id_t         rn_rd,
    input  tag_t            rn_tag,
    input  logic [NW-1:0]   cm_valid,
    input  reg_id_t         cm_id [NW],
    input  tag_t            cm_tag [NW],
    input  logic [NREG-1:0] ld_busy,
    input  tag_t            ld_tag [NREG],
    output tag_t            tag [NREG],
    output logic [NREG-1:0] cbusy
);
    logic [NREG-1:0] busy;
    // later (younger) ports override earlier ones, so only the youngest tag test counts
    always_comb begin
        cbusy = busy;
        for (int r = 0; r < NREG; r++)
            for (int k = 0; k < NW; k++)
                if (cm_valid[k] && cm_id[k] == REG_W'(r))
                    cbusy[r] = busy[r] && cm_tag[k] != tag[r];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
            tag  <= '{default: '0};
        end else if (en) begin
            if (load) begin
                busy <= ld_busy;
                tag  <= ld_tag;
            end else begin
                busy <= clear ? '0 : cbusy;
                if (!clear && rn_valid && rn_rd != '0) begin
                    busy[rn_rd] <= 1'b1;
                    tag[rn_rd]  <= rn_tag;
                end
            end
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with busy/tag tracking and read bypass
// Optional busy-table checkpointing is enabled by defining REGFILE_CHECKPOINT_EN.
module regfile_mp import regfile_pkg::*; #(parameter int NR = 2, parameter int NW = 2) (
    input logic          clk,
    input logic          rst,
    regfile_mp_if.slave  bus
);
    word_t           val [NREG];
    tag_t            l_tag [NREG];
    tag_t            s_tag [NREG];
    logic [NREG-1:0] l_cbusy, s_cbusy;
    logic [NW-1:0]   cm_en;
    logic            restore, load_live, rn_eff;
    logic [NR-1:0]   match;
    word_t           hval [NR];
    assign cm_en  = bus.cm_valid & {NW{bus.en}};
    assign rn_eff = bus.en && bus.rn_valid && bus.rn_rd != '0 && !bus.flush && !restore;
`ifdef REGFILE_CHECKPOINT_EN
    logic ckpt_v;
    assign restore        = bus.ckpt_restore;
    assign load_live      = bus.ckpt_restore && ckpt_v;
    assign bus.ckpt_valid = ckpt_v;
    always_ff @(posedge clk)
        if (rst) ckpt_v <= 1'b0;
        else if (bus.en) ckpt_v <= bus.ckpt_restore ? 1'b0 : bus.ckpt_save ? 1'b1 : ckpt_v;
    // snapshot captures the live table after commits, before rename, then follows commits itself
    regfile_busy_table #(.NW(NW)) u_snap (
        .clk, .rst, .en(bus.en), .clear(1'b0), .load(bus.ckpt_save),
        .rn_valid(1'b0), .rn_rd('0), .rn_tag('0),
        .cm_valid(cm_en), .cm_id(bus.cm_id), .cm_tag(bus.cm_tag),
        .ld_busy(l_cbusy), .ld_tag(l_tag), .tag(s_tag), .cbusy(s_cbusy)
    );
`else
    assign restore        = 1'b0;
    assign load_live      = 1'b0;
    assign bus.ckpt_valid = 1'b0;
    assign s_cbusy        = '0;
    assign s_tag          = '{default: '0};
`endif
    regfile_busy_table #(.NW(NW)) u_live (
        .clk, .rst, .en(bus.en), .clear(bus.flush || restore), .load(load_live),
        .rn_valid(bus.rn_valid), .rn_rd(bus.rn_rd), .rn_tag(bus.rn_tag),
        .cm_valid(cm_en), .cm_id(bus.cm_id), .cm_tag(bus.cm_tag),
        .ld_busy(s_cbusy), .ld_tag(s_tag), .tag(l_tag), .cbusy(l_cbusy)
    );
    always_ff @(posedge clk) begin
        if (rst) val <= '{default: '0};
        else if (bus.en)
            for (int k = 0; k < NW; k++)
                if (bus.cm_valid[k] && bus.cm_id[k] != '0) val[bus.cm_id[k]] <= bus.cm_val[k];
    end
    always_comb begin
        for (int p = 0; p < NR; p++) begin
            match[p] = 1'b0;
            hval[p]  = '0;
            for (int k = 0; k < NW; k++)
                if (cm_en[k] && bus.cm_id[k] != '0 && bus.cm_id[k] == bus.rd_id[p]) begin
                    match[p] = bus.cm_tag[k] == l_tag[bus.rd_id[p]];
                    hval[p]  = bus.cm_val[k];
                end
            bus.rd_busy[p] = (rn_eff && bus.rn_rd == bus.rd_id[p]) || l_cbusy[bus.rd_id[p]];
            bus.rd_tag[p]  = (rn_eff && bus.rn_rd == bus.rd_id[p]) ? bus.rn_tag : l_tag[bus.rd_id[p]];
            bus.rd_val[p]  = match[p] ? hval[p] : val[bus.rd_id[p]];
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp
module tb_regfile_mp;
    import regfile_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    regfile_mp_if bus ();
    regfile_mp dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", nm, obs, exp);
        end
    endtask
    task automatic idle();
        bus.flush = 1'b0;
        bus.rn_valid = 1'b0;
        bus.rn_rd = '0;
        bus.rn_tag = '0;
        bus.cm_valid = '0;
        bus.ckpt_save = 1'b0;
        bus.ckpt_restore = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.cm_id[k] = '0;
            bus.cm_tag[k] = '0;
            bus.cm_val[k] = '0;
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask
    task automatic rn(input reg_id_t r, input tag_t t);
        bus.rn_valid = 1'b1;
        bus.rn_rd = r;
        bus.rn_tag = t;
    endtask
    task automatic cm(input int k, input reg_id_t r, input tag_t t, input word_t v);
        bus.cm_valid[k] = 1'b1;
        bus.cm_id[k] = r;
        bus.cm_tag[k] = t;
        bus.cm_val[k] = v;
    endtask
    task automatic rd(input reg_id_t a, input reg_id_t b);
        bus.rd_id[0] = a;
        bus.rd_id[1] = b;
        #1;
    endtask

    initial begin
        bus.en = 1'b1;
        idle();
        rd(5'd5, 5'd0);
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", bus.rd_busy[0], 0);
        chk("rst_tag", bus.rd_tag[0], 0);
        chk("rst_val", bus.rd_val[0], 0);
        chk("rst_ckpt", bus.ckpt_valid, 0);
        // writes to x0 are dropped
        rn(5'd0, 5'd3);
        rd(5'd5, 5'd0);
        chk("x0_rn_byp", bus.rd_busy[1], 0);
        tick();
        chk("x0_busy", bus.rd_busy[1], 0);
        chk("x0_tag", bus.rd_tag[1], 0);
        cm(0, 5'd0, 5'd0, 32'h55);
        rd(5'd5, 5'd0);
        chk("x0_cm_byp", bus.rd_val[1], 0);
        tick();
        chk("x0_val", bus.rd_val[1], 0);
        // rename then matching commit with bypass
        rn(5'd5, 5'd7);
        tick();
        chk("t2_busy", bus.rd_busy[0], 1);
        chk("t2_tag", bus.rd_tag[0], 7);
        cm(0, 5'd5, 5'd7, 32'hAB);
        rd(5'd5, 5'd0);
        chk("t2_byp_busy", bus.rd_busy[0], 0);
        chk("t2_byp_val", bus.rd_val[0], 32'hAB);
        tick();
        chk("t2_busy2", bus.rd_busy[0], 0);
        chk("t2_val2", bus.rd_val[0], 32'hAB);
        // stale commit keeps busy
        rn(5'd5, 5'd7);
        tick();
        rn(5'd5, 5'd9);
        tick();
        cm(0, 5'd5, 5'd7, 32'h1);
        tick();
        chk("t3_busy", bus.rd_busy[0], 1);
        chk("t3_tag", bus.rd_tag[0], 9);
        chk("t3_val", bus.rd_val[0], 1);
        cm(1, 5'd5, 5'd9, 32'h2);
        tick();
        chk("t3_clr", bus.rd_busy[0], 0);
        chk("t3_val2", bus.rd_val[0], 2);
        // rename and commit same reg same cycle
        rn(5'd5, 5'd11);
        cm(0, 5'd5, 5'd9, 32'h3);
        tick();
        chk("rc_busy", bus.rd_busy[0], 1);
        chk("rc_tag", bus.rd_tag[0], 11);
        chk("rc_val", bus.rd_val[0], 3);
        // two commits to one reg: youngest port wins
        rn(5'd6, 5'd4);
        tick();
        cm(0, 5'd6, 5'd2, 32'd10);
        cm(1, 5'd6, 5'd4, 32'd20);
        rd(5'd5, 5'd6);
        chk("t4_byp_busy", bus.rd_busy[1], 0);
        chk("t4_byp_val", bus.rd_val[1], 20);
        tick();
        chk("t4_busy", bus.rd_busy[1], 0);
        chk("t4_val", bus.rd_val[1], 20);
        rn(5'd6, 5'd2);
        tick();
        cm(0, 5'd6, 5'd2, 32'd30);
        cm(1, 5'd6, 5'd4, 32'd40);
        tick();
        chk("t4b_busy", bus.rd_busy[1], 1);
        chk("t4b_tag", bus.rd_tag[1], 2);
        chk("t4b_val", bus.rd_val[1], 40);
        // flush with matching commit
        rn(5'd3, 5'd1);
        tick();
        rn(5'd4, 5'd2);
        tick();
        rd(5'd3, 5'd4);
        chk("t5_b3", bus.rd_busy[0], 1);
        chk("t5_b4", bus.rd_busy[1], 1);
        bus.flush = 1'b1;
        cm(0, 5'd3, 5'd1, 32'd5);
        tick();
        chk("t5_f3", bus.rd_busy[0], 0);
        chk("t5_v3", bus.rd_val[0], 5);
        chk("t5_f4", bus.rd_busy[1], 0);
        chk("t5_tag4", bus.rd_tag[1], 2);
        rd(5'd6, 5'd5);
        chk("t5_f6", bus.rd_busy[0], 0);
        chk("t5_f5", bus.rd_busy[1], 0);
        // en=0 holds state and disables bypass
        rd(5'd3, 5'd4);
        bus.en = 1'b0;
        rn(5'd3, 5'd8);
        cm(0, 5'd4, 5'd2, 32'd99);
        #1;
        chk("hold_byp_busy", bus.rd_busy[0], 0);
        chk("hold_byp_val", bus.rd_val[1], 0);
        tick();
        bus.en = 1'b1;
        #1;
        chk("hold_busy", bus.rd_busy[0], 0);
        chk("hold_val", bus.rd_val[1], 0);
        // flush ignores rename
        bus.flush = 1'b1;
        rn(5'd7, 5'd5);
        tick();
        rd(5'd7, 5'd0);
        chk("flush_rn", bus.rd_busy[0], 0);
`ifdef REGFILE_CHECKPOINT_EN
        rn(5'd3, 5'd1);
        tick();
        rn(5'd8, 5'd6);
        tick();
        bus.ckpt_save = 1'b1;
        rn(5'd4, 5'd2);
        tick();
        rd(5'd4, 5'd8);
        chk("t6_cv", bus.ckpt_valid, 1);
        chk("t6_b4", bus.rd_busy[0], 1);
        cm(0, 5'd3, 5'd1, 32'd7);
        tick();
        bus.ckpt_restore = 1'b1;
        tick();
        rd(5'd3, 5'd4);
        chk("t6_r3", bus.rd_busy[0], 0);
        chk("t6_r4", bus.rd_busy[1], 0);
        chk("t6_cv0", bus.ckpt_valid, 0);
        rd(5'd8, 5'd0);
        chk("t6_r8", bus.rd_busy[0], 1);
        chk("t6_t8", bus.rd_tag[0], 6);
        bus.ckpt_restore = 1'b1;
        tick();
        chk("t6_nv_flush", bus.rd_busy[0], 0);
`else
        bus.ckpt_save = 1'b1;
        tick();
        chk("nockpt_cv", bus.ckpt_valid, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
